gates_pipe: RTL and testbench
=============================

// Module: gates_pipe
// PURPOSE
//   WIDTH-bit successor to the single-bit two-input gate array. It adds per-transaction
//   operation select, a 2-stage registered pipeline with valid/ready backpressure,
//   result flags and a transaction counter. It sits between a stimulus/control source
//   and a consumer that may stall.
// PARAMETERS
//   WIDTH  8   operand/result width in bits (>=1)
//   CNT_W  16  width of completed-transaction counter
// PORTS
//   clk        in   1      single clock; all state on rising edge
//   rst_n      in   1      asynchronous reset, active low
//   clr        in   1      sync clear: flush pipeline, zero counter
//   in_valid   in   1      input transaction valid
//   in_ready   out  1      block can accept input this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   op         in   3      0 AND,1 NAND,2 OR,3 NOR,4 XOR,5 XNOR,6 NOT a,7 BUF a
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   y          out  WIDTH  bitwise result
//   y_zero     out  1      y == 0
//   y_parity   out  1      ^y (XOR reduction)
//   op_count   out  CNT_W  number of completed output handshakes, wraps mod 2^CNT_W
// BEHAVIOUR
//   Reset (rst_n=0, async): s1_valid=s2_valid=0, out_valid=0, y=0, y_zero=1 (y is 0),
//     y_parity=0, op_count=0. Internal operand registers are cleared to 0.
//   Stage 1 (S1) registers a, b, op. Stage 2 (S2) registers y and the flags computed
//     from S1. The flags are always consistent with the y register.
//   Accept rules (fire = valid & ready):
//     s2_adv   = !s2_valid | out_ready
//     s1_adv   = !s1_valid | s2_adv
//     in_ready = s1_adv & !clr   (purely combinational; no dependence on in_valid)
//   Latency: an input accepted at edge N gives out_valid=1 after edge N+1 (if not stalled).
//   Throughput: 1 transaction/cycle while out_ready=1.
//   Stall: out_valid=1 & out_ready=0 -> y and flags hold stable, and S2 holds.
//     S1 holds if it is full. Once both stages are full, in_ready=0.
//   Order: results leave in acceptance order. No drop, no duplication.
//   op_count increments by 1 on each out_valid&out_ready edge. It wraps from all-ones to 0.
//   clr=1 (sync, highest priority): next edge s1_valid=s2_valid=0 and op_count=0.
//     Any input presented that cycle is not accepted (in_ready=0).
//     An output handshake in that cycle is not counted.
//   Reset or clr mid-stream: in-flight transactions are discarded silently.
//   Bitwise ops act on all WIDTH bits. Op 6/7 ignore b. There are no undefined op codes.
// TESTING
//   (WIDTH=8) Reset: rst_n=0 mid-cycle -> out_valid=0, op_count=0, y=0 immediately,
//     with no clock edge required.
//   Op sweep a=8'hC5, b=8'h3A, op 0..7, out_ready=1 -> y=00,FF,FF,00,FF,00,3A,C5.
//     Each result appears 2 cycles after input, one per cycle, op_count=8 at the end.
//   Flags: a=8'h0F, b=8'h0F, op XOR -> y=00, y_zero=1, y_parity=0.
//     Then a=8'h07, op BUF -> y=07, y_zero=0, y_parity=1.
//   Backpressure: out_ready=0 while sending 3 inputs -> first 2 accepted, then in_ready=0.
//     y holds the first result. Release out_ready -> all 3 results arrive in order,
//     with no loss.
//   clr with both stages full -> next cycle out_valid=0, op_count=0.
//     The input presented during clr is not accepted.
//   Wrap: CNT_W=4, 17 handshakes -> op_count reads 1.

Source files
------------

// File: rtl/gates_pipe.sv
// Two-stage bitwise gate pipeline with valid/ready backpressure, result flags
// and a completed-transaction counter.
module gates_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero,
    output logic             y_parity,
    output logic [CNT_W-1:0] op_count
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_zero_q, y_zero_d;
    logic             y_parity_q, y_parity_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             s2_adv;
    logic             s1_adv;
    logic [WIDTH-1:0] result;

    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = s1_adv && !clr;
    assign out_valid = s2_valid_q;
    assign y         = y_q;
    assign y_zero    = y_zero_q;
    assign y_parity  = y_parity_q;
    assign op_count  = count_q;

    always_comb begin
        result = a_q;
        case (op_q)
            3'd0:    result = a_q & b_q;
            3'd1:    result = ~(a_q & b_q);
            3'd2:    result = a_q | b_q;
            3'd3:    result = ~(a_q | b_q);
            3'd4:    result = a_q ^ b_q;
            3'd5:    result = ~(a_q ^ b_q);
            3'd6:    result = ~a_q;
            default: result = a_q;
        endcase
    end

    // Flags are registered alongside y so they always describe the held result.
    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        s2_valid_d = s2_valid_q;
        y_d        = y_q;
        y_zero_d   = y_zero_q;
        y_parity_d = y_parity_q;
        count_d    = count_q;
        if (clr) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            count_d    = '0;
        end else begin
            if (s2_adv) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    y_d        = result;
                    y_zero_d   = (result == '0);
                    y_parity_d = ^result;
                end
            end
            if (s1_adv) begin
                s1_valid_d = in_valid;
                if (in_valid) begin
                    a_d  = a;
                    b_d  = b;
                    op_d = op;
                end
            end
            if (s2_valid_q && out_ready) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            y_zero_q   <= 1'b1;
            y_parity_q <= 1'b0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            s2_valid_q <= s2_valid_d;
            y_q        <= y_d;
            y_zero_q   <= y_zero_d;
            y_parity_q <= y_parity_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_gates_pipe.sv
// Self-checking bench for gates_pipe: a queue-based transaction model predicts
// readiness, result visibility, result values and the handshake count.
module tb_gates_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [2:0]  op = '0;

    logic        in_ready, out_valid, y_zero, y_parity;
    logic [7:0]  y;
    logic [15:0] op_count;
    logic        w_in_ready, w_out_valid, w_y_zero, w_y_parity;
    logic [7:0]  w_y;
    logic [3:0]  w_op_count;

    gates_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_zero(y_zero), .y_parity(y_parity), .op_count(op_count)
    );

    gates_pipe #(.WIDTH(8), .CNT_W(4)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(w_in_ready),
        .a(a), .b(b), .op(op), .out_valid(w_out_valid), .out_ready(out_ready),
        .y(w_y), .y_zero(w_y_zero), .y_parity(w_y_parity), .op_count(w_op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        int         acc;
    } ent_t;

    ent_t exp_q[$];
    int   cyc = 0;
    int   model_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    // Each op is a 2-input truth table indexed by {a_bit, b_bit}.
    function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] z, input logic [2:0] o);
        logic [3:0] tt [8];
        logic [7:0] r;
        tt = '{4'b1000, 4'b0111, 4'b1110, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b1100};
        r = '0;
        for (int i = 0; i < 8; i++) r[i] = tt[o][{x[i], z[i]}];
        return r;
    endfunction

    // The oldest transaction is visible once two edges have passed since acceptance.
    function automatic bit exp_ov();
        return (exp_q.size() > 0) && ((cyc - exp_q[0].acc) >= 2);
    endfunction

    function automatic bit exp_ir();
        return !clr && ((exp_q.size() < 2) || out_ready);
    endfunction

    task automatic model_edge();
        bit ov, ir;
        ov = exp_ov();
        ir = exp_ir();
        if (clr) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            if (ov && out_ready) begin
                void'(exp_q.pop_front());
                model_cnt++;
            end
            if (ir && in_valid) exp_q.push_back('{res: ref_op(a, b, op), acc: cyc});
        end
        cyc++;
    endtask

    task automatic finish_cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_op_sweep();
        logic [7:0] tab [8];
        int got;
        tab = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h3A, 8'hC5};
        got = 0;
        out_ready = 1'b1;
        a = 8'hC5;
        b = 8'h3A;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 8);
            op = 3'(i);
            @(negedge clk);
            checks++;
            if (out_valid !== exp_ov()) begin
                errors++;
                $display("[TB] FAIL sweep out_valid cycle %0d: got %b want %b", i, out_valid, exp_ov());
            end
            if (exp_ov() && got < 8) begin
                checks++;
                if ({y, y_zero, y_parity} !== {tab[got], tab[got] == 8'h00, ^tab[got]}) begin
                    errors++;
                    $display("[TB] FAIL sweep result op %0d: got y=%h z=%b p=%b want y=%h", got, y, y_zero, y_parity, tab[got]);
                end
                got++;
            end
            finish_cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (op_count !== 16'd8) begin
            errors++;
            $display("[TB] FAIL sweep op_count: got %0d want 8", op_count);
        end
    endtask

    task automatic test_flags();
        logic [9:0] want [2];
        int got;
        want = '{{8'h00, 1'b1, 1'b0}, {8'h07, 1'b0, 1'b1}};
        got = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 2);
            a = (i == 0) ? 8'h0F : 8'h07;
            b = 8'h0F;
            op = (i == 0) ? 3'd4 : 3'd7;
            @(negedge clk);
            if (exp_ov() && got < 2) begin
                checks++;
                if ({y, y_zero, y_parity} !== want[got]) begin
                    errors++;
                    $display("[TB] FAIL flags result %0d: got %h want %h", got, {y, y_zero, y_parity}, want[got]);
                end
                got++;
            end
            finish_cycle();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] ia [3];
        logic [7:0] ib [3];
        logic [2:0] io [3];
        int k;
        for (int i = 0; i < 3; i++) begin
            ia[i] = 8'($urandom);
            ib[i] = 8'($urandom);
            io[i] = 3'($urandom);
        end
        k = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = (k < 3);
            a = ia[k % 3];
            b = ib[k % 3];
            op = io[k % 3];
            @(negedge clk);
            checks++;
            if (in_ready !== exp_ir()) begin
                errors++;
                $display("[TB] FAIL stall in_ready cycle %0d: got %b want %b", i, in_ready, exp_ir());
            end
            if (exp_ov()) begin
                checks++;
                if (y !== ref_op(ia[0], ib[0], io[0])) begin
                    errors++;
                    $display("[TB] FAIL stall hold y: got %h want %h", y, ref_op(ia[0], ib[0], io[0]));
                end
            end
            if (in_valid && exp_ir()) k++;
            finish_cycle();
        end
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall full: got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = (k < 3);
            a = ia[k % 3];
            b = ib[k % 3];
            op = io[k % 3];
            @(negedge clk);
            checks++;
            if (out_valid !== exp_ov()) begin
                errors++;
                $display("[TB] FAIL drain out_valid: got %b want %b", out_valid, exp_ov());
            end
            if (exp_ov()) begin
                checks++;
                if (y !== exp_q[0].res) begin
                    errors++;
                    $display("[TB] FAIL drain order y: got %h want %h", y, exp_q[0].res);
                end
            end
            if (in_valid && exp_ir()) k++;
            finish_cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (op_count !== 16'd13) begin
            errors++;
            $display("[TB] FAIL drain op_count: got %0d want 13", op_count);
        end
    endtask

    task automatic test_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a = 8'($urandom);
            b = 8'($urandom);
            op = 3'($urandom);
            @(negedge clk);
            finish_cycle();
        end
        clr = 1'b1;
        out_ready = 1'b1;
        a = 8'h55;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clr cycle: got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
        end
        finish_cycle();
        clr = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || op_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL after clr: got out_valid=%b op_count=%0d want 0 0", out_valid, op_count);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL clr input leaked: got out_valid=%b want 0", out_valid);
            end
            finish_cycle();
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        for (int i = 0; i < 21; i++) begin
            in_valid = (i < 17);
            a = 8'($urandom);
            b = 8'($urandom);
            op = 3'($urandom);
            @(negedge clk);
            if (exp_ov()) begin
                checks++;
                if (w_y !== exp_q[0].res) begin
                    errors++;
                    $display("[TB] FAIL wrap stream y: got %h want %h", w_y, exp_q[0].res);
                end
            end
            finish_cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (w_op_count !== 4'd1 || op_count !== 16'd17) begin
            errors++;
            $display("[TB] FAIL wrap count: got %0d/%0d want 1/17", w_op_count, op_count);
        end
    endtask

    task automatic test_random();
        logic [7:0] ey;
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            clr = ($urandom_range(39) == 0);
            a = 8'($urandom);
            b = 8'($urandom);
            op = 3'($urandom);
            @(negedge clk);
            checks++;
            if ({in_ready, out_valid} !== {exp_ir(), exp_ov()}) begin
                errors++;
                $display("[TB] FAIL rand handshake %0d: got rdy=%b vld=%b want %b %b", i, in_ready, out_valid, exp_ir(), exp_ov());
            end
            checks++;
            if ({w_in_ready, w_out_valid} !== {exp_ir(), exp_ov()}) begin
                errors++;
                $display("[TB] FAIL rand narrow handshake %0d: got %b %b want %b %b", i, w_in_ready, w_out_valid, exp_ir(), exp_ov());
            end
            if (exp_ov()) begin
                ey = exp_q[0].res;
                checks++;
                if ({y, y_zero, y_parity} !== {ey, ey == 8'h00, ^ey}) begin
                    errors++;
                    $display("[TB] FAIL rand result %0d: got y=%h z=%b p=%b want %h", i, y, y_zero, y_parity, ey);
                end
                checks++;
                if ({w_y, w_y_zero, w_y_parity} !== {ey, ey == 8'h00, ^ey}) begin
                    errors++;
                    $display("[TB] FAIL rand narrow result %0d: got %h want %h", i, w_y, ey);
                end
            end
            checks++;
            if (op_count !== 16'(model_cnt) || w_op_count !== 4'(model_cnt)) begin
                errors++;
                $display("[TB] FAIL rand op_count %0d: got %0d/%0d want %0d", i, op_count, w_op_count, model_cnt);
            end
            finish_cycle();
        end
        clr = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 8'($urandom) | 8'h01;
            b = 8'($urandom);
            op = 3'd7;
            @(negedge clk);
            finish_cycle();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || op_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset state: got out_valid=%b op_count=%0d want 0 0", out_valid, op_count);
        end
        checks++;
        if ({y, y_zero, y_parity} !== {8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset y/flags: got y=%h z=%b p=%b want 00 1 0", y, y_zero, y_parity);
        end
        exp_q.delete();
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post-reset: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        finish_cycle();
    endtask

    initial begin
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_op_sweep();
        test_flags();
        test_backpressure();
        test_clear();
        test_wrap();
        test_random();
        test_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
